lidar_scan_controller: RTL and testbench

Parametrised successor to the single-shot LiDAR bring-up/scan top level. Drives the RPLIDAR-style UART byte interface end to end:
- sends the scan and stop commands;
- checks the 7-byte response descriptor;
- parses 5-byte measurement packets;
- buffers accepted measurements in a FIFO drained through a valid/ready handshake.

It sits between the uart_tx/uart_rx byte engines and the downstream mapping/display logic.

---
 rtl/lidar_pkg.sv | 24 ++
 rtl/lidar_scan_controller_meas_fifo.sv | 38 +++
 rtl/lidar_scan_controller.sv | 144 ++++++++++++++
 tb/tb_lidar_scan_controller.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lidar_pkg.sv
// lidar_pkg: shared states, command bytes, descriptor and measurement type for the LiDAR scan controller
package lidar_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    WAIT_DESC = 3'd2,
    SCAN      = 3'd3,
    SEND_STOP = 3'd4,
    ERROR     = 3'd5
  } state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] SCAN_BYTE = 8'h20;
  localparam logic [7:0] STOP_BYTE = 8'h25;
  localparam logic [6:0][7:0] DESC = {8'h81, 8'h40, 8'h00, 8'h00, 8'h05, 8'h5A, 8'hA5};
  typedef struct packed {
    logic [14:0] angle;
    logic [15:0] distance;
    logic [5:0]  quality;
    logic        s;
  } meas_t;
  localparam int ERR_OVF  = 0;
  localparam int ERR_DESC = 1;
  localparam int ERR_TMO  = 2;
endpackage

// File: rtl/lidar_scan_controller_meas_fifo.sv
// meas_fifo: first-word-fall-through measurement FIFO with wrap-bit pointers and synchronous flush
module meas_fifo
  import lidar_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk_in,
  input  logic  rst_n_in,
  input  logic  flush,
  input  logic  push,
  input  meas_t din,
  input  logic  pop,
  output meas_t dout,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  meas_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];
  // pointers advance only on accepted push/pop; flush empties without touching storage
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  // storage write for accepted pushes
  always_ff @(posedge clk_in)
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/lidar_scan_controller.sv
// lidar_scan_controller: RPLIDAR scan start/stop, descriptor check, packet parse and FIFO buffering.
// Optional LIDAR_PKT_CHECK_EN: validate S/S-bar and check bit, resyncing and counting bad packets.
module lidar_scan_controller
  import lidar_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int MIN_QUALITY    = 0,
  parameter int DROP_W         = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              run_in,
  output logic [7:0]        tx_data_out,
  output logic              tx_start_out,
  input  logic              tx_done_in,
  input  logic [7:0]        rx_data_in,
  input  logic              rx_valid_in,
  output logic              meas_valid_out,
  input  logic              meas_ready_in,
  output logic [14:0]       angle_out,
  output logic [15:0]       distance_out,
  output logic [5:0]        quality_out,
  output logic              new_rev_out,
  output logic [2:0]        state_out,
  output logic [2:0]        error_out,
  output logic [DROP_W-1:0] drop_count_out
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic tx_busy, tx_idx, tx_go, tmo, start, scan_rx, resync, bad0, bad1, drop, q_ok;
  logic pkt_vld, fifo_full, fifo_empty, s_acc;
  logic [2:0] rx_idx;
  logic [TW-1:0] tmo_cnt;
  logic [5:0] q_acc;
  logic [14:0] ang_acc;
  logic [7:0] dist_lo;
  logic [1:0] drop_inc;
  logic [DROP_W:0] drop_sum;
  meas_t pkt, head, head_q;
  assign start    = state == IDLE && run_in;
  assign scan_rx  = state == SCAN && run_in && rx_valid_in;
  assign tmo      = tmo_cnt == TW'(TIMEOUT_CYCLES - 1) && !rx_valid_in;
  assign q_ok     = int'(q_acc) >= MIN_QUALITY;
`ifdef LIDAR_PKT_CHECK_EN
  assign bad0 = rx_idx == 3'd0 && rx_data_in[0] == rx_data_in[1];
  assign bad1 = rx_idx == 3'd1 && !rx_data_in[0];
`else
  assign bad0 = 1'b0;
  assign bad1 = 1'b0;
`endif
  assign resync   = scan_rx && (bad0 || bad1);
  assign drop     = pkt_vld && fifo_full;
  assign drop_inc = {1'b0, drop} + {1'b0, resync};
  assign drop_sum = {1'b0, drop_count_out} + (DROP_W+1)'(drop_inc);
  // state register
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= state_n;
  // next state and tx issue; a byte in flight always finishes before leaving a send state
  always_comb begin
    state_n = state;
    tx_go   = 1'b0;
    case (state)
      IDLE: state_n = run_in ? SEND_CMD : IDLE;
      SEND_CMD: begin
        tx_go = !tx_busy && run_in;
        if (!tx_busy && !run_in) state_n = SEND_STOP;
        else if (tx_busy && tx_done_in && tx_idx) state_n = run_in ? WAIT_DESC : SEND_STOP;
      end
      WAIT_DESC:
        if (!run_in) state_n = SEND_STOP;
        else if (rx_valid_in && rx_data_in != DESC[rx_idx]) state_n = ERROR;
        else if (tmo) state_n = ERROR;
        else if (rx_valid_in && rx_idx == 3'd6) state_n = SCAN;
      SCAN: state_n = !run_in ? SEND_STOP : tmo ? ERROR : SCAN;
      SEND_STOP: begin
        tx_go = !tx_busy;
        if (tx_busy && tx_done_in && tx_idx) state_n = IDLE;
      end
      ERROR: state_n = run_in ? ERROR : SEND_STOP;
      default: state_n = IDLE;
    endcase
  end
  // byte sequencing, timeout, packet assembly, error and drop bookkeeping
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      tx_busy        <= 1'b0;
      tx_idx         <= 1'b0;
      rx_idx         <= 3'd0;
      tmo_cnt        <= '0;
      q_acc          <= '0;
      s_acc          <= 1'b0;
      ang_acc        <= '0;
      dist_lo        <= '0;
      pkt            <= '0;
      pkt_vld        <= 1'b0;
      error_out      <= '0;
      drop_count_out <= '0;
    end else begin
      tx_busy <= tx_go || (tx_busy && !tx_done_in);
      tx_idx  <= state_n != state ? 1'b0 : tx_idx || (tx_busy && tx_done_in);
      tmo_cnt <= (state_n != state || rx_valid_in) ? '0 : tmo_cnt + TW'(1);
      if (state_n != state) rx_idx <= 3'd0;
      else if (state == WAIT_DESC && rx_valid_in) rx_idx <= rx_idx + 3'd1;
      else if (scan_rx) rx_idx <= (resync || rx_idx == 3'd4) ? 3'd0 : rx_idx + 3'd1;
      if (scan_rx && rx_idx == 3'd0) {q_acc, s_acc} <= {rx_data_in[7:2], rx_data_in[0]};
      if (scan_rx && rx_idx == 3'd1) ang_acc[6:0] <= rx_data_in[7:1];
      if (scan_rx && rx_idx == 3'd2) ang_acc[14:7] <= rx_data_in;
      if (scan_rx && rx_idx == 3'd3) dist_lo <= rx_data_in;
      if (scan_rx && rx_idx == 3'd4) pkt <= {ang_acc, rx_data_in, dist_lo, q_acc, s_acc};
      pkt_vld <= scan_rx && rx_idx == 3'd4 && q_ok;
      if (start) begin
        error_out      <= '0;
        drop_count_out <= '0;
      end else begin
        if (drop) error_out[ERR_OVF] <= 1'b1;
        if (state_n == ERROR && state != ERROR && tmo) error_out[ERR_TMO] <= 1'b1;
        if (state_n == ERROR && state != ERROR && !tmo) error_out[ERR_DESC] <= 1'b1;
        drop_count_out <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
    end
  meas_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .flush    (start),
    .push     (pkt_vld),
    .din      (pkt),
    .pop      (meas_ready_in),
    .dout     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
  assign head_q         = fifo_empty ? '0 : head;
  assign meas_valid_out = !fifo_empty;
  assign angle_out      = head_q.angle;
  assign distance_out   = head_q.distance;
  assign quality_out    = head_q.quality;
  assign new_rev_out    = head_q.s;
  assign state_out      = state;
  assign tx_start_out   = tx_go;
  assign tx_data_out    = (state == SEND_CMD || state == SEND_STOP) ?
                          (!tx_idx ? SYNC_BYTE : state == SEND_CMD ? SCAN_BYTE : STOP_BYTE) : 8'h00;
endmodule

// File: tb/tb_lidar_scan_controller.sv
// tb_lidar_scan_controller: randomized scenario bench with a queue-based packet model and UART tx responder
module tb_lidar_scan_controller;
  localparam int DEPTH = 16;
  localparam int TMO   = 300;
  localparam int MINQ  = 4;
  localparam int DW    = 16;
  logic clk_in = 1'b0, rst_n_in = 1'b0, run_in = 1'b0, tx_done_in = 1'b0;
  logic rx_valid_in = 1'b0, meas_ready_in = 1'b0;
  logic [7:0] rx_data_in = 8'h00;
  logic [7:0] tx_data_out;
  logic tx_start_out, meas_valid_out, new_rev_out;
  logic [14:0] angle_out;
  logic [15:0] distance_out;
  logic [5:0] quality_out;
  logic [2:0] state_out, error_out;
  logic [DW-1:0] drop_count_out;
  int vectors = 0, miscompares = 0;
  logic [7:0] tx_log[$];
  logic [7:0] desc[7] = '{8'hA5, 8'h5A, 8'h05, 8'h00, 8'h00, 8'h40, 8'h81};
  wire [37:0] head = {angle_out, distance_out, quality_out, new_rev_out};

  lidar_scan_controller #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .MIN_QUALITY(MINQ), .DROP_W(DW)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .run_in(run_in),
    .tx_data_out(tx_data_out), .tx_start_out(tx_start_out), .tx_done_in(tx_done_in),
    .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
    .meas_valid_out(meas_valid_out), .meas_ready_in(meas_ready_in),
    .angle_out(angle_out), .distance_out(distance_out), .quality_out(quality_out),
    .new_rev_out(new_rev_out), .state_out(state_out), .error_out(error_out),
    .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  // uart_tx stand-in: log each started byte and return tx_done a few cycles later
  initial forever begin
    @(posedge clk_in); #1;
    while (tx_start_out && rst_n_in) begin
      tx_log.push_back(tx_data_out);
      repeat (3) @(posedge clk_in);
      #1 tx_done_in = 1'b1;
      @(posedge clk_in);
      #1 tx_done_in = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data_in = b;
    rx_valid_in = 1'b1;
    @(posedge clk_in);
    #1 rx_valid_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [37:0] p);
    logic [7:0] b[5];
    b[0] = {p[6:1], ~p[0], p[0]};
    b[1] = {p[29:23], 1'b1};
    b[2] = p[37:30];
    b[3] = p[14:7];
    b[4] = p[22:15];
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin @(posedge clk_in); #1; end
      send_byte(b[i]);
    end
  endtask

  task automatic do_start(input int bad_pos, output bit ok);
    tx_log.delete();
    run_in = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk_in); #1;
      ok = state_out == 3'd2;
    end
    if (ok)
      for (int i = 0; i < 7; i++) begin
        send_byte(i == bad_pos ? 8'h01 : desc[i]);
        @(posedge clk_in); #1;
      end
  endtask

  task automatic do_stop(output bit ok);
    tx_log.delete();
    run_in = 1'b0;
    ok = state_out == 3'd0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk_in); #1;
      ok = state_out == 3'd0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_in);
    #1;
    vectors++;
    if ({state_out, tx_data_out, tx_start_out, meas_valid_out, head, error_out, drop_count_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs state=%0d tx=%h err=%b drop=%0d valid=%b, required all 0",
               state_out, tx_data_out, error_out, drop_count_out, meas_valid_out);
    end
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    vectors++;
    if (state_out !== 3'd0 || meas_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: state=%0d valid=%b, required 0 0", state_out, meas_valid_out);
    end
  endtask

  task automatic test_start();
    bit ok;
    do_start(-1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL start_wait_desc: state=%0d, required 2 within 100 cycles", state_out);
    end
    vectors++;
    if (tx_log.size() != 2) begin
      miscompares++;
      $display("FAIL start_tx_count: %0d bytes, required 2", tx_log.size());
    end else if ({tx_log[0], tx_log[1]} !== 16'hA520) begin
      miscompares++;
      $display("FAIL start_tx_bytes: %h %h, required a5 20", tx_log[0], tx_log[1]);
    end
    vectors++;
    if (state_out !== 3'd3 || error_out !== 3'b000) begin
      miscompares++;
      $display("FAIL start_scan: state=%0d err=%b, required 3 000", state_out, error_out);
    end
  endtask

  task automatic test_packet();
    logic [7:0] raw[5] = '{8'h3E, 8'h01, 8'h2D, 8'h40, 8'h1F};
    meas_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin @(posedge clk_in); #1; end
      send_byte(raw[i]);
    end
    @(negedge clk_in);
    vectors++;
    if (meas_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL pkt_latency_early: valid=%b one cycle after byte4, required 0", meas_valid_out);
    end
    @(negedge clk_in);
    vectors++;
    if (meas_valid_out !== 1'b1 || head !== {15'h1680, 16'h1F40, 6'd15, 1'b0}) begin
      miscompares++;
      $display("FAIL pkt_fields: valid=%b angle=%h dist=%h q=%0d s=%b, required 1 1680 1f40 15 0",
               meas_valid_out, angle_out, distance_out, quality_out, new_rev_out);
    end
    @(posedge clk_in); #1;
    meas_ready_in = 1'b0;
    @(negedge clk_in);
    vectors++;
    if (meas_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL pkt_pop: valid=%b after pop, required 0", meas_valid_out);
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_random();
    logic [37:0] pk[12];
    logic [37:0] exp_q[$];
    logic [37:0] e;
    bit sent = 1'b0;
    int cyc = 0;
    for (int i = 0; i < 12; i++) begin
      pk[i] = {15'($urandom), 16'($urandom), 6'($urandom), 1'($urandom)};
      if (int'(pk[i][6:1]) >= MINQ) exp_q.push_back(pk[i]);
    end
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send_pkt(pk[i]);
          repeat ($urandom_range(0, 3)) begin @(posedge clk_in); #1; end
        end
        sent = 1'b1;
      end
      begin
        while (cyc < 3000 && !(sent && exp_q.size() == 0)) begin
          @(posedge clk_in); #1;
          meas_ready_in = 1'($urandom);
          cyc++;
          @(negedge clk_in);
          if (meas_valid_out && meas_ready_in) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL rand_extra: unexpected entry %h", head);
            end else begin
              e = exp_q.pop_front();
              if (head !== e) begin
                miscompares++;
                $display("FAIL rand_entry: got %h, required %h", head, e);
              end
            end
          end
        end
      end
    join
    @(posedge clk_in); #1;
    meas_ready_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    vectors++;
    if (exp_q.size() != 0 || meas_valid_out !== 1'b0 || drop_count_out !== '0) begin
      miscompares++;
      $display("FAIL rand_tail: missing=%0d valid=%b drop=%0d, required 0 0 0",
               exp_q.size(), meas_valid_out, drop_count_out);
    end
  endtask

  task automatic test_overflow();
    logic [37:0] pk[20];
    bit ok;
    int k = 0;
    do_stop(ok);
    do_start(-1, ok);
    meas_ready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pk[i] = {15'($urandom), 16'($urandom), 6'($urandom_range(MINQ, 63)), 1'($urandom)};
      send_pkt(pk[i]);
      @(posedge clk_in); #1;
    end
    repeat (3) @(posedge clk_in);
    #1;
    vectors++;
    if (drop_count_out !== 16'd4 || error_out !== 3'b001 || meas_valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_status: drop=%0d err=%b valid=%b, required 4 001 1",
               drop_count_out, error_out, meas_valid_out);
    end
    for (int cyc = 0; cyc < 1000 && k < 16; cyc++) begin
      @(posedge clk_in); #1;
      meas_ready_in = 1'($urandom);
      @(negedge clk_in);
      if (meas_valid_out && meas_ready_in) begin
        vectors++;
        if (head !== pk[k]) begin
          miscompares++;
          $display("FAIL ovf_order: entry %0d got %h, required %h", k, head, pk[k]);
        end
        k++;
      end
    end
    @(posedge clk_in); #1;
    meas_ready_in = 1'b0;
    vectors++;
    if (k != 16 || meas_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_drain: drained %0d valid=%b, required 16 0", k, meas_valid_out);
    end
  endtask

  task automatic test_bad_desc();
    bit ok;
    do_stop(ok);
    do_start(4, ok);
    vectors++;
    if (state_out !== 3'd5 || error_out !== 3'b010) begin
      miscompares++;
      $display("FAIL bad_desc: state=%0d err=%b, required 5 010", state_out, error_out);
    end
    do_stop(ok);
    vectors++;
    if (!ok || tx_log.size() != 2) begin
      miscompares++;
      $display("FAIL stop_seq: state=%0d bytes=%0d, required 0 2", state_out, tx_log.size());
    end else if ({tx_log[0], tx_log[1]} !== 16'hA525) begin
      miscompares++;
      $display("FAIL stop_bytes: %h %h, required a5 25", tx_log[0], tx_log[1]);
    end
    vectors++;
    if (error_out !== 3'b010) begin
      miscompares++;
      $display("FAIL err_hold_idle: err=%b, required 010", error_out);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n = 0;
    do_start(-1, ok);
    vectors++;
    if (state_out !== 3'd3 || error_out !== 3'b000) begin
      miscompares++;
      $display("FAIL restart_clear: state=%0d err=%b, required 3 000", state_out, error_out);
    end
    while (n < TMO + 50 && state_out !== 3'd5) begin
      @(posedge clk_in); #1;
      n++;
    end
    vectors++;
    if (n < TMO - 5 || n > TMO + 2 || error_out !== 3'b100) begin
      miscompares++;
      $display("FAIL timeout: after %0d silent cycles err=%b, required about %0d and 100", n, error_out, TMO);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_stop(ok);
    do_start(-1, ok);
    meas_ready_in = 1'b0;
    send_pkt({15'h1234, 16'hBEEF, 6'd40, 1'b1});
    @(posedge clk_in); #1;
    send_byte(8'hC5);
    @(posedge clk_in); #1;
    send_byte(8'h81);
    vectors++;
    if (state_out !== 3'd3 || meas_valid_out !== 1'b1 || head !== {15'h1234, 16'hBEEF, 6'd40, 1'b1}) begin
      miscompares++;
      $display("FAIL pre_reset: state=%0d valid=%b head=%h, required 3 1 %h",
               state_out, meas_valid_out, head, {15'h1234, 16'hBEEF, 6'd40, 1'b1});
    end
    #2 rst_n_in = 1'b0;
    run_in = 1'b0;
    #1;
    vectors++;
    if ({state_out, tx_data_out, tx_start_out, meas_valid_out, head, error_out, drop_count_out} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: state=%0d valid=%b head=%h err=%b drop=%0d, required all 0",
               state_out, meas_valid_out, head, error_out, drop_count_out);
    end
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
  endtask

`ifdef LIDAR_PKT_CHECK_EN
  task automatic test_resync();
    bit ok;
    do_start(-1, ok);
    meas_ready_in = 1'b0;
    send_byte(8'h3F);
    @(posedge clk_in); #1;
    send_pkt({15'h2A55, 16'h0C80, 6'd20, 1'b1});
    repeat (3) @(posedge clk_in);
    #1;
    vectors++;
    if (drop_count_out !== 16'd1 || meas_valid_out !== 1'b1 || head !== {15'h2A55, 16'h0C80, 6'd20, 1'b1}) begin
      miscompares++;
      $display("FAIL resync: drop=%0d valid=%b head=%h, required 1 1 %h",
               drop_count_out, meas_valid_out, head, {15'h2A55, 16'h0C80, 6'd20, 1'b1});
    end
    do_stop(ok);
  endtask
`endif

  initial begin
    bit ok;
    test_reset();
    test_start();
    test_packet();
    test_random();
    test_overflow();
    test_bad_desc();
    test_timeout();
    test_async_reset();
`ifdef LIDAR_PKT_CHECK_EN
    test_resync();
`endif
    do_stop(ok);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
